// File: rtl/timing_adapter_param_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// timing_adapter_param_if
// Avalon-ST bundle for the timing adapter: the source side (in_*) and the
// sink side (out_*) travel together so the adapter has a single bus port.
//
// Handshake semantics:
//   Source side: the adapter drives in_ready; a beat is offered whenever
//   in_valid is high. A well-behaved source only raises in_valid in a cycle
//   where in_ready was high IN_READY_LATENCY cycles earlier.
//   Sink side, latency 0: a beat transfers in every cycle where out_valid and
//   out_ready are both high. Latency L > 0: out_valid may only rise L cycles
//   after out_ready was high, and every out_valid beat is a transfer.
//
// Modports:
//   slave  - the adapter (drives in_ready and all out_* except out_ready)
//   master - the environment (drives in_* and out_ready)
// -----------------------------------------------------------------------------
interface timing_adapter_param_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int EMPTY_WIDTH = 2,
   parameter int ERROR_WIDTH = 1
);
   logic                   in_ready;
   logic                   in_valid;
   logic [DATA_WIDTH-1:0]  in_data;
   logic                   in_startofpacket;
   logic                   in_endofpacket;
   logic [EMPTY_WIDTH-1:0] in_empty;
   logic [ERROR_WIDTH-1:0] in_error;

   logic                   out_ready;
   logic                   out_valid;
   logic [DATA_WIDTH-1:0]  out_data;
   logic                   out_startofpacket;
   logic                   out_endofpacket;
   logic [EMPTY_WIDTH-1:0] out_empty;
   logic [ERROR_WIDTH-1:0] out_error;

   modport slave (
      output in_ready,
      input  in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, in_error,
      input  out_ready,
      output out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, out_error
   );

   modport master (
      input  in_ready,
      output in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, in_error,
      output out_ready,
      input  out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, out_error
   );
endinterface

// File: rtl/timing_adapter_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// timing_adapter_param
// Avalon-ST timing adapter: accepts beats from a source with ready latency
// IN_READY_LATENCY and presents them to a sink with ready latency
// OUT_READY_LATENCY through a show-ahead FIFO of DEPTH entries.
//
// Ports:
//   clk          - clock, rising edge
//   reset_n      - asynchronous active-low reset
//   bus          - timing_adapter_param_if.slave (in_* source side, out_* sink side)
//   fill_level   - registered FIFO occupancy, 0..DEPTH
//   overflow     - sticky: a beat was dropped because the FIFO was full
//   protocol_err - sticky: in_valid seen in a cycle without a ready grant
// -----------------------------------------------------------------------------
module timing_adapter_param #(
   parameter int DATA_WIDTH        = 32,
   parameter int EMPTY_WIDTH       = 2,
   parameter int ERROR_WIDTH       = 1,
   parameter int IN_READY_LATENCY  = 3,
   parameter int OUT_READY_LATENCY = 0,
   parameter int DEPTH             = 8,
   parameter int FILL_WIDTH        = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   timing_adapter_param_if.slave bus,
   output logic [FILL_WIDTH-1:0] fill_level,
   output logic                  overflow,
   output logic                  protocol_err
);

   localparam int WORD_WIDTH = DATA_WIDTH + 2 + EMPTY_WIDTH + ERROR_WIDTH;
   localparam int PTR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_WIDTH-1:0]  LAST_PTR    = PTR_WIDTH'(DEPTH - 1);
   localparam logic [FILL_WIDTH-1:0] FULL_LEVEL  = FILL_WIDTH'(DEPTH);
   // Leaves room for every beat the source may still send inside its
   // latency window after in_ready is seen high.
   localparam logic [FILL_WIDTH-1:0] READY_LIMIT = FILL_WIDTH'(DEPTH - 1 - IN_READY_LATENCY);

   // Elaboration-time parameter sanity checks
   if (DEPTH < IN_READY_LATENCY + 1) begin : g_bad_depth
      $error("timing_adapter_param: DEPTH must be >= IN_READY_LATENCY+1");
   end
   if (DEPTH >= (1 << FILL_WIDTH)) begin : g_bad_fill_width
      $error("timing_adapter_param: FILL_WIDTH too narrow to hold DEPTH");
   end
   if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > 7 ||
       OUT_READY_LATENCY < 0 || OUT_READY_LATENCY > 7) begin : g_bad_latency
      $error("timing_adapter_param: ready latencies must be 0..7");
   end

   logic [WORD_WIDTH-1:0] mem [0:DEPTH-1];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [WORD_WIDTH-1:0] in_word;
   logic [WORD_WIDTH-1:0] head_word;
   logic                  grant;
   logic                  full;
   logic                  not_empty;
   logic                  push;
   logic                  pop;
   logic                  drop;

   function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
      // Explicit wrap so DEPTH need not be a power of two
      return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   assign in_word = {bus.in_data, bus.in_startofpacket, bus.in_endofpacket,
                     bus.in_empty, bus.in_error};

   assign full      = (fill_level == FULL_LEVEL);
   assign not_empty = (fill_level != '0);

   assign bus.in_ready = (fill_level <= READY_LIMIT);

   // ---------------------------------------------------------------------
   // Grant: in_ready as the source saw it IN_READY_LATENCY cycles ago
   // ---------------------------------------------------------------------
   if (IN_READY_LATENCY == 0) begin : g_grant_comb
      assign grant = bus.in_ready;
   end else begin : g_grant_dly
      logic [IN_READY_LATENCY-1:0] ready_dly;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            ready_dly <= '0;
         end else begin
            ready_dly[0] <= bus.in_ready;
            for (int i = 1; i < IN_READY_LATENCY; i++) begin
               ready_dly[i] <= ready_dly[i-1];
            end
         end
      end
      assign grant = ready_dly[IN_READY_LATENCY-1];
   end

   // ---------------------------------------------------------------------
   // Sink side: with a non-zero latency the sink has committed to accept
   // whatever is presented, so every out_valid beat is a pop.
   // ---------------------------------------------------------------------
   if (OUT_READY_LATENCY == 0) begin : g_out_comb
      assign bus.out_valid = not_empty;
      assign pop           = not_empty && bus.out_ready;
   end else begin : g_out_dly
      logic [OUT_READY_LATENCY-1:0] rd_dly;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rd_dly <= '0;
         end else begin
            rd_dly[0] <= bus.out_ready;
            for (int i = 1; i < OUT_READY_LATENCY; i++) begin
               rd_dly[i] <= rd_dly[i-1];
            end
         end
      end
      assign bus.out_valid = rd_dly[OUT_READY_LATENCY-1] && not_empty;
      assign pop           = bus.out_valid;
   end

   // A pop in the same cycle frees the head slot, so a full FIFO can still
   // take a beat then.
   assign push = bus.in_valid && (!full || pop);
   assign drop = bus.in_valid && full && !pop;

   // Show-ahead: head entry is always on the output
   assign head_word = mem[rd_ptr];
   assign {bus.out_data, bus.out_startofpacket, bus.out_endofpacket,
           bus.out_empty, bus.out_error} = head_word;

   // Storage carries no reset; it is only observed while fill_level != 0
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_word;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_level   <= '0;
         overflow     <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fill_level <= fill_level + FILL_WIDTH'(1);
            2'b01:   fill_level <= fill_level - FILL_WIDTH'(1);
            default: fill_level <= fill_level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
         if (bus.in_valid && !grant) begin
            protocol_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/timing_adapter_param.md
Name: timing_adapter_param

Overview:
Parametrised Avalon-ST timing adapter for the TSE client-interface testbench models. It bridges a source with ready latency IN_READY_LATENCY to a sink with ready latency OUT_READY_LATENCY, using an internal show-ahead FIFO. Data, empty and error widths are configurable. Sticky overflow and protocol-violation flags support bench checking. It generalises the fixed 32-bit, latency-3-to-0 adapter.

Parameters:
DATA_WIDTH, 32, payload data width
EMPTY_WIDTH, 2, width of empty field
ERROR_WIDTH, 1, width of error field
IN_READY_LATENCY, 3, source ready latency (0..7)
OUT_READY_LATENCY, 0, sink ready latency (0..7)
DEPTH, 8, FIFO entries; must be >= IN_READY_LATENCY+1 (elaboration check); full throughput needs >= 2*IN_READY_LATENCY+2
FILL_WIDTH, 4, width of fill_level; must hold DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_ready  out  1  ready to source
in_valid  in  1  source beat valid
in_data  in  DATA_WIDTH  source data
in_startofpacket  in  1  SOP
in_endofpacket  in  1  EOP
in_empty  in  EMPTY_WIDTH  empty symbols on EOP beat
in_error  in  ERROR_WIDTH  error
out_ready  in  1  sink ready
out_valid  out  1  beat valid to sink
out_data  out  DATA_WIDTH  data
out_startofpacket  out  1  SOP
out_endofpacket  out  1  EOP
out_empty  out  EMPTY_WIDTH  empty
out_error  out  ERROR_WIDTH  error
fill_level  out  FILL_WIDTH  FIFO occupancy
overflow  out  1  sticky: beat dropped, FIFO full
protocol_err  out  1  sticky: in_valid with no ready grant

Behaviour:
- Reset (reset_n low, async): FIFO pointers/fill = 0, ready delay lines = 0, overflow = 0, protocol_err = 0. Consequently out_valid = 0; in_ready = 1 if DEPTH-1-IN_READY_LATENCY >= 0 (always true by constraint). Payload outputs don't-care while out_valid = 0.
- Payload: {data, sop, eop, empty, error} is stored as one word, width DATA_WIDTH+2+EMPTY_WIDTH+ERROR_WIDTH. Show-ahead: head entry is driven combinationally on out_* whenever non-empty.
- in_ready is combinational from registered fill: in_ready = (fill_level <= DEPTH-1-IN_READY_LATENCY). This guarantees space for every beat granted inside the latency window.
- Grant tracking: in_ready is delayed IN_READY_LATENCY cycles to form grant (grant = in_ready when latency = 0).
- Push: in_valid and not full. If in_valid, full and no simultaneous pop: beat dropped, overflow set. If in_valid and not grant: protocol_err set, but the beat is still pushed if space exists.
- Out side, OUT_READY_LATENCY = 0: out_valid = (fill != 0); pop = out_valid and out_ready.
- Out side, OUT_READY_LATENCY = L > 0: out_ready is delayed L cycles to form rd_ok; out_valid = rd_ok and (fill != 0); pop = out_valid (the sink must accept).
- Simultaneous push and pop: fill unchanged. Push into an empty FIFO is visible on out_* the next cycle (1-cycle minimum latency, no bypass).
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- fill_level = registered count, 0..DEPTH.
- Sticky flags clear only on reset.
- Reset asserted mid-packet: all contents discarded; no partial beat appears after release.

Test Plan:
1. Defaults, source honours latency 3, sink out_ready = 1, 20 back-to-back beats with data 0..19 -> out_data 0..19 in order, first out_valid 1 cycle after first push, overflow = 0, protocol_err = 0.
2. Defaults, sink out_ready = 0, source streams until in_ready drops -> in_ready falls when fill_level reaches 5; fill_level peaks at exactly 8; overflow stays 0.
3. Source ignores in_ready, pushes 9 beats into a stalled FIFO -> 9th beat dropped, overflow = 1, protocol_err = 1, fill_level = 8; after drain, the first 8 beats emerge intact.
4. OUT_READY_LATENCY = 2, out_ready toggled 1,0,1,1,0 starting at cycle t, FIFO pre-loaded with 4 beats -> out_valid = 1 exactly in cycles t+2, t+4 and t+5, popping beats 0, 1 and 2.
5. DATA_WIDTH = 64, EMPTY_WIDTH = 3, 3-beat packet (sop, -, eop with empty = 5, error = 1) -> identical sop/eop/empty/error on output.
6. reset_n pulsed low asynchronously mid-packet with fill_level = 6 -> fill_level = 0, out_valid = 0, flags = 0 immediately; after release, in_ready = 1 and new traffic passes cleanly.
